// File: rtl/gray_code_counter.sv
// Up/down counter that registers a binary count and its matching Gray code, with step-flip mask and wrap pulse.
// Latency: 1 cycle from the sampled rst/load/en to the outputs; every output comes straight from a flop.
// Backpressure: none; one step per enabled cycle, and load takes priority over en.
module gray_code_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_bin,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] flip,
    output logic         tc
);

    logic [W-1:0] step_bin;
    logic [W-1:0] step_gray;
    logic [W-1:0] load_gray;
    logic         step_wrap;

    always_comb begin
        step_bin  = up ? (bin + 1'b1) : (bin - 1'b1);
        step_gray = step_bin ^ (step_bin >> 1);
        load_gray = load_bin ^ (load_bin >> 1);
        // Wrap is decided from the pre-step value, so direction changes are handled per edge.
        step_wrap = up ? (&bin) : ~(|bin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            flip <= '0;
            tc   <= 1'b0;
        end else if (load) begin
            bin  <= load_bin;
            gray <= load_gray;
            flip <= '0;
            tc   <= 1'b0;
        end else if (en) begin
            bin  <= step_bin;
            gray <= step_gray;
            flip <= gray ^ step_gray;
            tc   <= step_wrap;
        end else begin
            flip <= '0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter at W=3 and W=8 side by side: scoreboard against an integer model plus Gray invariants.
module tb_gray_code_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] lb = 8'd0;

    logic [2:0] bin3, gray3, flip3;
    logic       tc3;
    logic [7:0] bin8, gray8, flip8;
    logic       tc8;

    gray_code_counter #(.W(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb[2:0]),
        .bin(bin3), .gray(gray3), .flip(flip3), .tc(tc3)
    );

    gray_code_counter #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(lb),
        .bin(bin8), .gray(gray8), .flip(flip8), .tc(tc8)
    );

    typedef struct {
        logic [7:0] b3, g3, f3;
        logic       t3;
        logic [7:0] b8, g8, f8;
        logic       t8;
        bit         stepped;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m3 = 0;
    int   m8 = 0;

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    function automatic int gray_dec(input int g, input int w);
        int b = 0;
        int acc = 0;
        for (int i = w - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            b = b | (acc << i);
        end
        return b;
    endfunction

    task automatic model_step(input int m, input int n, output int nm, output int f, output bit t);
        nm = m;
        f = 0;
        t = 1'b0;
        if (rst) nm = 0;
        else if (load) nm = int'(lb) % n;
        else if (en) begin
            nm = up ? (m + 1) % n : (m + n - 1) % n;
            t = up ? (m == n - 1) : (m == 0);
            f = gray_of(m) ^ gray_of(nm);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int v);
        exp_t x;
        int nm3, nm8, f3, f8;
        bit t3, t8;
        rst = r; en = e; up = u; load = l; lb = v[7:0];
        @(posedge clk);
        model_step(m3, 8, nm3, f3, t3);
        model_step(m8, 256, nm8, f8, t8);
        m3 = nm3;
        m8 = nm8;
        x.b3 = 8'(nm3); x.g3 = 8'(gray_of(nm3)); x.f3 = 8'(f3); x.t3 = t3;
        x.b8 = 8'(nm8); x.g8 = 8'(gray_of(nm8)); x.f8 = 8'(f8); x.t8 = t8;
        x.stepped = !r && !l && e;
        q.push_back(x);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("bin3", int'(bin3), int'(e.b3));
                check("gray3", int'(gray3), int'(e.g3));
                check("flip3", int'(flip3), int'(e.f3));
                check("tc3", int'(tc3), int'(e.t3));
                check("bin8", int'(bin8), int'(e.b8));
                check("gray8", int'(gray8), int'(e.g8));
                check("flip8", int'(flip8), int'(e.f8));
                check("tc8", int'(tc8), int'(e.t8));
                check("decode3", gray_dec(int'(gray3), 3), int'(bin3));
                check("decode8", gray_dec(int'(gray8), 8), int'(bin8));
                check("onehot3", $countones(flip3), e.stepped ? 1 : 0);
                check("onehot8", $countones(flip8), e.stepped ? 1 : 0);
            end
        end
    end

    initial begin : stimulus
        int gtab[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
        int r;

        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 5);
        check("reset_all3", int'({bin3, gray3, flip3, tc3}), 0);

        // Count up through a full wrap.
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 0, 0);
            check("up_gray_seq", int'(gray3), gtab[i]);
            check("up_tc_seq", int'(tc3), (i == 7) ? 1 : 0);
        end

        // Count down from reset wraps immediately.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check("down_wrap", int'({bin3, gray3, flip3, tc3}), int'({3'd7, 3'b100, 3'b100, 1'b1}));
        drive(0, 1, 0, 0, 0);
        check("down_next", int'({bin3, gray3, tc3}), int'({3'd6, 3'b101, 1'b0}));

        // Load beats en.
        drive(0, 1, 1, 1, 5);
        check("load_wins", int'({bin3, gray3, flip3, tc3}), int'({3'd5, 3'b111, 3'b000, 1'b0}));

        // Hold and direction change.
        drive(1, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 1, 0, 0);
        repeat (2) drive(0, 0, 1, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0);
        check("hold_dir_bin", int'(bin3), 1);

        // Reset mid-operation, then resume.
        drive(0, 0, 0, 1, 6);
        drive(1, 1, 1, 1, 3);
        check("rst_mid", int'({bin3, gray3, flip3, tc3, bin8}), 0);
        repeat (2) drive(0, 1, 1, 0, 0);
        check("resume_bin", int'(bin3), 2);

        for (int i = 0; i < 10000; i++) begin
            r = int'($urandom_range(0, 999));
            drive(r < 5, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
